nios_onchip_mem_arbiter: RTL

//  Two-requester arbiter that shares the single-port on-chip memory
//  (4 x 32-bit, byte-enabled) between master 0 and master 1.

---
 rtl/nios_onchip_mem_arbiter_if.sv | 36 +++
 rtl/nios_onchip_mem_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/nios_onchip_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// nios_onchip_mem_arbiter_if
// One Avalon-MM style master port as seen by the on-chip memory arbiter.
//   address       word address driven by the master
//   byteenable    byte lanes of the access
//   read / write  request strobes (write wins when both are high)
//   writedata     write data
//   waitrequest   request not accepted this cycle (arbiter -> master)
//   readdata      read data (arbiter -> master)
//   readdatavalid read data valid, one cycle after a read issue
// Modports: master (requester side), slave (arbiter side).
// ---------------------------------------------------------------------------
interface nios_onchip_mem_arbiter_if #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
);
  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/nios_onchip_mem_arbiter.sv
// ---------------------------------------------------------------------------
// nios_onchip_mem_arbiter
// Shares one single-port on-chip memory (4 x 32 bit, byte enabled) between
// two Avalon-MM masters. At most one access is issued per cycle; read data
// comes back one cycle after issue to the master that issued the read.
// Arbitration is round-robin with a bounded hold (FIXED_PRI=0) or fixed
// priority to master 0 (FIXED_PRI=1).
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   reset_req         memory clock-enable inhibit; nothing issues while high
//   m0, m1            master ports (slave modport of the interface)
//   mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata
//                     memory access outputs (combinational from the grant)
//   mem_clken         memory clock enable (= ~reset_req)
//   mem_readdata      memory q, valid one cycle after the address
// ---------------------------------------------------------------------------

// Protocol invariants of the arbiter, kept apart from the datapath.
module nios_onchip_mem_arbiter_chk (
  input logic clk,
  input logic reset,
  input logic reset_req,
  input logic gnt0,
  input logic gnt1,
  input logic mem_chipselect,
  input logic mem_write,
  input logic mem_clken
);
  a_onehot_gnt : assert property (@(posedge clk) disable iff (reset) !(gnt0 && gnt1))
    else $error("arbiter: both masters granted");
  a_no_issue_in_req : assert property (@(posedge clk) disable iff (reset) reset_req |-> !mem_chipselect)
    else $error("arbiter: access issued while reset_req high");
  a_write_needs_cs : assert property (@(posedge clk) disable iff (reset) mem_write |-> mem_chipselect)
    else $error("arbiter: write strobe without chipselect");
  a_clken : assert property (@(posedge clk) disable iff (reset) mem_clken == !reset_req)
    else $error("arbiter: clken does not follow reset_req");
endmodule

module nios_onchip_mem_arbiter #(
  parameter int ADDR_W    = 2,
  parameter int DATA_W    = 32,
  parameter int BE_W      = 4,
  parameter int HOLD_MAX  = 4,
  parameter int FIXED_PRI = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 reset_req,
  nios_onchip_mem_arbiter_if.slave m0,
  nios_onchip_mem_arbiter_if.slave m1,
  output logic [ADDR_W-1:0]    mem_address,
  output logic [BE_W-1:0]      mem_byteenable,
  output logic                 mem_chipselect,
  output logic                 mem_write,
  output logic [DATA_W-1:0]    mem_writedata,
  output logic                 mem_clken,
  input  logic [DATA_W-1:0]    mem_readdata
);

  // Which master currently "owns" the round-robin slot.
  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } owner_e;

  localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

  logic       req0_s;
  logic       req1_s;
  logic       gnt0_s;
  logic       gnt1_s;
  logic       issue_s;
  logic       rd_issue_s;
  owner_e     owner_r;
  owner_e     owner_nxt_s;
  logic [3:0] hold_cnt_r;
  logic [3:0] hold_cnt_nxt_s;
  logic       rd_vld_r;
  logic       rd_id_r;

  assign req0_s = m0.read | m0.write;
  assign req1_s = m1.read | m1.write;

  // Grant decision: combinational from requests, owner and hold count.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (reset || reset_req) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else if (req0_s && req1_s) begin
      if (FIXED_PRI != 0) begin
        gnt0_s = 1'b1;
        gnt1_s = 1'b0;
      end else if (hold_cnt_r < HOLD_LIM) begin
        // Owner keeps the slot until it has used up its hold budget.
        gnt0_s = (owner_r == OWN_M0);
        gnt1_s = (owner_r == OWN_M1);
      end else begin
        gnt0_s = (owner_r == OWN_M1);
        gnt1_s = (owner_r == OWN_M0);
      end
    end else begin
      gnt0_s = req0_s;
      gnt1_s = req1_s;
    end
  end

  assign issue_s = gnt0_s | gnt1_s;
  // A granted request with write low is a read; write wins over read.
  assign rd_issue_s = (gnt0_s & ~m0.write) | (gnt1_s & ~m1.write);

  // Memory-side mux: the granted master drives the memory this cycle.
  always_comb begin
    mem_chipselect = issue_s;
    mem_address    = m0.address;
    mem_byteenable = m0.byteenable;
    mem_writedata  = m0.writedata;
    mem_write      = 1'b0;
    if (gnt1_s) begin
      mem_address    = m1.address;
      mem_byteenable = m1.byteenable;
      mem_writedata  = m1.writedata;
      mem_write      = m1.write;
    end else if (gnt0_s) begin
      mem_write      = m0.write;
    end else begin
      mem_write      = 1'b0;
    end
  end

  assign mem_clken = ~reset_req;

  assign m0.waitrequest = req0_s & ~gnt0_s;
  assign m1.waitrequest = req1_s & ~gnt1_s;

  // Memory q is broadcast; readdatavalid selects the destination. Valid is
  // masked during reset so a read issued just before reset is dropped.
  assign m0.readdata      = mem_readdata;
  assign m1.readdata      = mem_readdata;
  assign m0.readdatavalid = rd_vld_r & (rd_id_r == 1'b0) & ~reset;
  assign m1.readdatavalid = rd_vld_r & (rd_id_r == 1'b1) & ~reset;

  // Next owner / hold count: saturating count of consecutive owner grants.
  always_comb begin
    owner_nxt_s    = owner_r;
    hold_cnt_nxt_s = hold_cnt_r;
    if (!issue_s) begin
      hold_cnt_nxt_s = 4'd0;
    end else if (gnt1_s == (owner_r == OWN_M1)) begin
      if (hold_cnt_r >= HOLD_LIM) begin
        hold_cnt_nxt_s = HOLD_LIM;
      end else begin
        hold_cnt_nxt_s = hold_cnt_r + 4'd1;
      end
    end else begin
      owner_nxt_s    = gnt1_s ? OWN_M1 : OWN_M0;
      hold_cnt_nxt_s = 4'd1;
    end
  end

  // Arbitration state and pending-read tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_r    <= OWN_M0;
      hold_cnt_r <= 4'd0;
      rd_vld_r   <= 1'b0;
      rd_id_r    <= 1'b0;
    end else begin
      owner_r    <= owner_nxt_s;
      hold_cnt_r <= hold_cnt_nxt_s;
      rd_vld_r   <= rd_issue_s;
      if (rd_issue_s) begin
        rd_id_r <= gnt1_s;
      end else begin
        rd_id_r <= rd_id_r;
      end
    end
  end

  nios_onchip_mem_arbiter_chk u_chk (
    .clk            (clk),
    .reset          (reset),
    .reset_req      (reset_req),
    .gnt0           (gnt0_s),
    .gnt1           (gnt1_s),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_clken      (mem_clken)
  );

endmodule
